// File: rtl/mem_port_arbiter.sv
// Purpose : two-requester arbiter in front of one memory read port and one write port.
// Latency : grant is combinational in the request cycle; read data returns one cycle after the grant.
// Backpressure: a requester holds its beat until gntN; the other requester is stalled while a locked burst runs.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   req/we/lock/addr/wdataN  per-requester beat request (0 = CPU data port, 1 = DMA/loader)
//   gntN                  beat accepted this cycle (combinational)
//   rvalidN, rdataN       read return, one cycle after the accepted read
//   mem_*                 shared memory: read address, read data (1-cycle latency), write enable/address/data
module mem_port_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 8
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              req0,
    input  logic              we0,
    input  logic              lock0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,

    input  logic              req1,
    input  logic              we1,
    input  logic              lock1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,

    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,

    output logic [ADDR_W-1:0] mem_raddr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [DATA_W-1:0] mem_wdata
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    // Burst limit widened by one bit so burst_cnt+1 never wraps before the compare.
    localparam logic [CNT_W:0] BURST_LIM = (CNT_W + 1)'(MAX_BURST);
    localparam logic [CNT_W:0] CNT_ONE   = (CNT_W + 1)'(1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] OWN0 = 2'd1;
    localparam logic [1:0] OWN1 = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic             last_winner;
    logic             last_winner_nxt;
    logic [CNT_W-1:0] burst_cnt;
    logic [CNT_W-1:0] burst_cnt_nxt;
    logic             rvalid0_q;
    logic             rvalid1_q;

    // ------------------------------------------------------------------
    // Arbitration view for this cycle.
    // An owner that drops its request releases immediately, so the cycle is
    // arbitrated as if already IDLE, with the releasing owner counted as the
    // last winner and the burst count starting from zero.
    // ------------------------------------------------------------------
    logic             arb_open;
    logic             arb_last;
    logic [CNT_W-1:0] cnt_base;

    always_comb begin
        arb_open = 1'b0;
        arb_last = last_winner;
        cnt_base = burst_cnt;
        case (state)
            OWN0: begin
                if (!req0) begin
                    arb_open = 1'b1;
                    arb_last = 1'b0;
                    cnt_base = '0;
                end
            end
            OWN1: begin
                if (!req1) begin
                    arb_open = 1'b1;
                    arb_last = 1'b1;
                    cnt_base = '0;
                end
            end
            default: begin
                // IDLE, and the unused encoding recovers as IDLE
                arb_open = 1'b1;
                arb_last = last_winner;
                cnt_base = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Grants. While owned and still requesting, the owner is the only
    // candidate; otherwise a tie goes to the requester that did not win last.
    // ------------------------------------------------------------------
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!reset) begin
            if (arb_open) begin
                if (req0 && req1) begin
                    gnt0 = arb_last;
                    gnt1 = !arb_last;
                end else begin
                    gnt0 = req0;
                    gnt1 = req1;
                end
            end else if (state == OWN0) begin
                gnt0 = 1'b1;   // not open in OWN0 implies req0 is high
            end else begin
                gnt1 = 1'b1;   // not open in OWN1 implies req1 is high
            end
        end
    end

    // ------------------------------------------------------------------
    // Ownership / burst bookkeeping
    // ------------------------------------------------------------------
    logic             beat;
    logic             beat_lock;
    logic [CNT_W:0]   cnt_inc;

    assign beat      = gnt0 | gnt1;
    assign beat_lock = gnt1 ? lock1 : lock0;
    assign cnt_inc   = {1'b0, cnt_base} + CNT_ONE;

    always_comb begin
        state_nxt       = state;
        last_winner_nxt = last_winner;
        burst_cnt_nxt   = burst_cnt;
        if (beat) begin
            if (beat_lock && (cnt_inc < BURST_LIM)) begin
                state_nxt     = gnt1 ? OWN1 : OWN0;
                burst_cnt_nxt = cnt_inc[CNT_W-1:0];
            end else begin
                // unlocked beat or burst limit reached: hand the port back
                state_nxt       = IDLE;
                burst_cnt_nxt   = '0;
                last_winner_nxt = gnt1;
            end
        end else if (arb_open) begin
            // Released owner with nobody taking the port; in IDLE arb_last
            // equals last_winner, so this holds the winner unchanged.
            state_nxt       = IDLE;
            burst_cnt_nxt   = '0;
            last_winner_nxt = arb_last;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            burst_cnt   <= '0;
            last_winner <= 1'b1;   // so the first post-reset tie goes to requester 0
            rvalid0_q   <= 1'b0;
            rvalid1_q   <= 1'b0;
        end else begin
            state       <= state_nxt;
            burst_cnt   <= burst_cnt_nxt;
            last_winner <= last_winner_nxt;
            rvalid0_q   <= gnt0 & ~we0;
            rvalid1_q   <= gnt1 & ~we1;
        end
    end

    // ------------------------------------------------------------------
    // Memory side. The address/data mux defaults to requester 0 when idle.
    // ------------------------------------------------------------------
    assign mem_raddr = gnt1 ? addr1  : addr0;
    assign mem_waddr = gnt1 ? addr1  : addr0;
    assign mem_wdata = gnt1 ? wdata1 : wdata0;
    assign mem_wen   = (gnt0 & we0) | (gnt1 & we1);

    // A read accepted just before reset rises would otherwise return its
    // rvalid during the reset cycle; masking with reset drops it.
    assign rvalid0 = rvalid0_q & ~reset;
    assign rvalid1 = rvalid1_q & ~reset;
    assign rdata0  = mem_rdata;
    assign rdata1  = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
// Bench for mem_port_arbiter: directed sequence plus a random soak, with a
// read-return scoreboard and per-cycle grant/starvation checks.
module tb_mem_port_arbiter;

    localparam int MB = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0, we0, lock0, req1, we1, lock1;
    logic [31:0] addr0, wdata0, addr1, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1;
    logic [31:0] rdata0, rdata1;
    logic [31:0] mem_raddr, mem_rdata, mem_waddr, mem_wdata;
    logic        mem_wen;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_BURST(MB)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .we0(we0), .lock0(lock0), .addr0(addr0), .wdata0(wdata0),
        .req1(req1), .we1(we1), .lock1(lock1), .addr1(addr1), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1),
        .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata0(rdata0), .rdata1(rdata1),
        .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
        .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata)
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic r0, input logic w0, input logic l0,
                         input logic [31:0] a0, input logic [31:0] d0,
                         input logic r1, input logic w1, input logic l1,
                         input logic [31:0] a1, input logic [31:0] d1);
        req0 = r0; we0 = w0; lock0 = l0; addr0 = a0; wdata0 = d0;
        req1 = r1; we1 = w1; lock1 = l1; addr1 = a1; wdata1 = d1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Memory: one-cycle read latency, write on mem_wen.
    logic [31:0] tbmem [256];
    initial begin
        for (int i = 0; i < 256; i++) tbmem[i] = 32'hC0DE_0000 | 32'(i);
        mem_rdata <= '0;
        forever begin
            @(posedge clk);
            mem_rdata <= tbmem[mem_raddr[7:0]];
            if (mem_wen) tbmem[mem_waddr[7:0]] = mem_wdata;
        end
    end

    // Scoreboard and per-cycle protocol checks.
    typedef struct packed {
        logic        port;
        logic [31:0] data;
    } sb_t;

    sb_t         sb [$];
    sb_t         sb_e;
    logic [31:0] shadow [256];
    logic        exp_rv0 = 1'b0;
    logic        exp_rv1 = 1'b0;
    int          wait0 = 0;
    int          wait1 = 0;

    initial begin
        for (int i = 0; i < 256; i++) shadow[i] = 32'hC0DE_0000 | 32'(i);
        forever begin
            @(negedge clk);
            if (reset) begin
                sb.delete();
                exp_rv0 = 1'b0;
                exp_rv1 = 1'b0;
                wait0 = 0;
                wait1 = 0;
            end else begin
                chk1("rvalid0_timing", rvalid0, exp_rv0);
                chk1("rvalid1_timing", rvalid1, exp_rv1);
                if ((exp_rv0 || exp_rv1) && sb.size() != 0) begin
                    sb_e = sb.pop_front();
                    if (sb_e.port) chk32("rdata1_sb", rdata1, sb_e.data);
                    else           chk32("rdata0_sb", rdata0, sb_e.data);
                end
                chk1("gnt_exclusive", gnt0 & gnt1, 1'b0);
                chk1("gnt0_needs_req", gnt0 & ~req0, 1'b0);
                chk1("gnt1_needs_req", gnt1 & ~req1, 1'b0);

                exp_rv0 = gnt0 && req0 && !we0;
                exp_rv1 = gnt1 && req1 && !we1;
                if (exp_rv0) sb.push_back('{port: 1'b0, data: shadow[addr0[7:0]]});
                if (exp_rv1) sb.push_back('{port: 1'b1, data: shadow[addr1[7:0]]});
                if (gnt0 && req0 && we0) shadow[addr0[7:0]] = wdata0;
                if (gnt1 && req1 && we1) shadow[addr1[7:0]] = wdata1;

                wait0 = (req0 && !gnt0) ? wait0 + 1 : 0;
                wait1 = (req1 && !gnt1) ? wait1 + 1 : 0;
                chk1("starve0", wait0 <= MB + 1, 1'b1);
                chk1("starve1", wait1 <= MB + 1, 1'b1);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // ---- reset holds grants and rvalid low ----
        reset = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 1'b0, 32'h20, 32'h0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk1("rst_gnt0", gnt0, 1'b0);
            chk1("rst_gnt1", gnt1, 1'b0);
            chk1("rst_wen", mem_wen, 1'b0);
            chk1("rst_rvalid0", rvalid0, 1'b0);
            chk1("rst_rvalid1", rvalid1, 1'b0);
            next_cycle();
        end
        reset = 1'b0;

        // ---- contention without lock: strict alternation starting at 0 ----
        drive(1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 1'b0, 32'h20, 32'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk1("alt_gnt0", gnt0, i % 2 == 0);
            chk1("alt_gnt1", gnt1, i % 2 == 1);
            next_cycle();
        end

        // ---- locked burst by 0 is cut at MAX_BURST beats ----
        drive(1'b1, 1'b0, 1'b1, 32'h30, 32'h0, 1'b1, 1'b0, 1'b0, 32'h31, 32'h0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk1("burst_gnt0", gnt0, i != MB);
            chk1("burst_gnt1", gnt1, i == MB);
            next_cycle();
        end

        // ---- nobody requesting: muxes follow requester 0, owner releases ----
        drive(1'b0, 1'b0, 1'b0, 32'h11, 32'h5, 1'b0, 1'b0, 1'b0, 32'h22, 32'h6);
        @(negedge clk);
        chk1("idle_gnt0", gnt0, 1'b0);
        chk1("idle_gnt1", gnt1, 1'b0);
        chk32("idle_raddr", mem_raddr, 32'h11);
        chk32("idle_wdata", mem_wdata, 32'h5);
        next_cycle();

        // ---- write then read back through requester 1 ----
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h40, 32'hDEADBEEF);
        @(negedge clk);
        chk1("wr_gnt1", gnt1, 1'b1);
        chk1("wr_wen", mem_wen, 1'b1);
        chk32("wr_waddr", mem_waddr, 32'h40);
        chk32("wr_wdata", mem_wdata, 32'hDEADBEEF);
        next_cycle();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h40, 32'h0);
        @(negedge clk);
        chk1("rd_gnt1", gnt1, 1'b1);
        chk1("rd_wen", mem_wen, 1'b0);
        chk32("rd_raddr", mem_raddr, 32'h40);
        next_cycle();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk1("rd_rvalid1", rvalid1, 1'b1);
        chk1("rd_rvalid0", rvalid0, 1'b0);
        chk32("rd_rdata1", rdata1, 32'hDEADBEEF);
        next_cycle();

        // ---- owner 1 locked, drops req mid-burst: 0 granted same cycle ----
        drive(1'b0, 1'b0, 1'b0, 32'h50, 32'h0, 1'b1, 1'b0, 1'b1, 32'h60, 32'h0);
        @(negedge clk);
        chk1("own1_first", gnt1, 1'b1);
        next_cycle();
        drive(1'b1, 1'b0, 1'b1, 32'h50, 32'h0, 1'b1, 1'b0, 1'b1, 32'h61, 32'h0);
        @(negedge clk);
        chk1("own1_hold_gnt1", gnt1, 1'b1);
        chk1("own1_block_gnt0", gnt0, 1'b0);
        next_cycle();
        drive(1'b1, 1'b0, 1'b1, 32'h52, 32'h0, 1'b0, 1'b0, 1'b0, 32'h62, 32'h0);
        @(negedge clk);
        chk1("release_gnt0", gnt0, 1'b1);
        chk1("release_gnt1", gnt1, 1'b0);
        next_cycle();
        // Release cycle was beat 1 of a fresh burst: seven more, then 1 gets in.
        drive(1'b1, 1'b0, 1'b1, 32'h52, 32'h0, 1'b1, 1'b0, 1'b0, 32'h62, 32'h0);
        for (int i = 1; i <= MB; i++) begin
            @(negedge clk);
            chk1("fresh_burst_gnt0", gnt0, i < MB);
            chk1("fresh_burst_gnt1", gnt1, i == MB);
            next_cycle();
        end

        // ---- reset right after an accepted read ----
        drive(1'b1, 1'b0, 1'b0, 32'h70, 32'h0, 1'b0, 1'b0, 1'b0, 32'h71, 32'h0);
        @(negedge clk);
        chk1("pre_rst_gnt0", gnt0, 1'b1);
        next_cycle();
        reset = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 32'h70, 32'h0, 1'b1, 1'b0, 1'b0, 32'h71, 32'h0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk1("midrst_rvalid0", rvalid0, 1'b0);
            chk1("midrst_rvalid1", rvalid1, 1'b0);
            chk1("midrst_gnt0", gnt0, 1'b0);
            chk1("midrst_gnt1", gnt1, 1'b0);
            next_cycle();
        end
        reset = 1'b0;
        @(negedge clk);
        chk1("postrst_gnt0", gnt0, 1'b1);
        chk1("postrst_gnt1", gnt1, 1'b0);
        chk1("postrst_rvalid0", rvalid0, 1'b0);
        next_cycle();
        @(negedge clk);
        chk1("postrst_rvalid0_b", rvalid0, 1'b1);
        chk1("postrst_gnt1_b", gnt1, 1'b1);
        next_cycle();

        // ---- random soak ----
        for (int i = 0; i < 10000; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)), $urandom(),
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)), $urandom());
            next_cycle();
        end

        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (3) next_cycle();
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, memory address width.
REQ-002 SHALL have parameter DATA_W, default 32, memory data width.
REQ-003 SHALL have parameter MAX_BURST, default 8, maximum consecutive locked beats per owner (legal range 1..255).
REQ-004 SHALL use one clock and a synchronous, active-high reset, with ports named clk and reset as the codebase does.
REQ-005 SHALL have these ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- req0, req1  in  1  requester n wants a beat; 0 = CPU data port, 1 = DMA/loader.
- we0, we1  in  1  beat is a write (1) or read (0).
- lock0, lock1  in  1  request to keep ownership after this beat.
- addr0, addr1  in  ADDR_W  beat address.
- wdata0, wdata1  in  DATA_W  write data.
- gnt0, gnt1  out  1  beat accepted this cycle (combinational).
- rvalid0, rvalid1  out  1  read data valid.
- rdata0, rdata1  out  DATA_W  read data.
- mem_raddr  out  ADDR_W  shared memory read-port address.
- mem_rdata  in  DATA_W  memory read data, valid one cycle after mem_raddr.
- mem_wen  out  1  memory write enable.
- mem_waddr  out  ADDR_W  memory write address.
- mem_wdata  out  DATA_W  memory write data.

Function
REQ-006 SHALL accept at most one beat per cycle; a beat is accepted when reqN && gntN at a rising clk edge.
REQ-007 SHALL keep gnt0 and gnt1 mutually exclusive, with gntN asserted only while reqN is asserted.
REQ-008 SHALL implement FSM states IDLE, OWN0 and OWN1, plus a last_winner bit and a burst_cnt counter of width clog2(MAX_BURST+1).
REQ-009 In IDLE, SHALL grant a sole requester; if both request, SHALL grant the requester that is not last_winner.
REQ-010 In OWNn, SHALL grant only requester n; the other requester SHALL see gnt=0 even when requesting.
REQ-011 On an accepted beat with lockN=1 and burst_cnt+1 < MAX_BURST, SHALL move to or stay in OWNn and increment burst_cnt.
REQ-012 On an accepted beat with lockN=0, SHALL go to IDLE, clear burst_cnt and set last_winner=N.
REQ-013 When burst_cnt+1 reaches MAX_BURST, SHALL go to IDLE, clear burst_cnt and set last_winner=N regardless of lockN.
REQ-014 In OWNn with reqn=0, SHALL release to IDLE in that cycle, so the other requester may be granted combinationally in the same cycle; last_winner SHALL be set to n.
REQ-015 SHALL drive mem_raddr, mem_waddr and mem_wdata from the granted requester's signals; with no grant, SHALL drive them from requester 0.
REQ-016 SHALL drive mem_wen = accepted beat && weN.
REQ-017 For an accepted read, SHALL assert rvalidN for exactly one cycle, one cycle after acceptance, with rdataN = mem_rdata in that cycle.
REQ-018 For writes, SHALL never assert rvalid.
REQ-019 SHALL drive rdata0 and rdata1 from mem_rdata at all times; they are qualified only by rvalid.
REQ-020 SHALL sustain back-to-back reads with full throughput: rvalid for beat k coincides with acceptance of beat k+1.
REQ-021 With MAX_BURST=1, lock SHALL have no effect and arbitration SHALL be pure alternation under contention.

Reset
REQ-022 While reset=1, SHALL force gnt0=gnt1=0 and mem_wen=0.
REQ-023 On the first clk edge with reset=1, SHALL set state=IDLE, burst_cnt=0, last_winner=1 and rvalid0=rvalid1=0.
REQ-024 Reset during a burst or with a read in flight SHALL discard the pending rvalid, and no rvalid SHALL appear after reset deasserts.
REQ-025 After reset deasserts, with both requesting, SHALL grant requester 0 first.

Verification
REQ-026 Both req continuously, lock=0, reads: grants alternate 0,1,0,1 starting with 0 after reset; each rvalid arrives one cycle after its grant.
REQ-027 req0 lock0=1 for 10 beats with MAX_BURST=8 and req1 held high: gnt0 for 8 consecutive cycles, then gnt1 for 1 cycle, then gnt0 again.
REQ-028 req1 write, addr1=0x40, wdata1=0xDEADBEEF; next cycle req1 read 0x40: mem_wen=1 with mem_waddr=0x40 in cycle 1; rvalid1=1 with rdata1=0xDEADBEEF in cycle 3.
REQ-029 Owner 1 locked, drops req1 mid-burst while req0 is high: gnt0=1 in that same cycle and burst_cnt is cleared.
REQ-030 Reset asserted in the cycle after an accepted read: rvalid stays 0, gnt is 0 during reset, and the first post-reset tie grants requester 0.
REQ-031 Random req/we/lock on both requesters for 10k cycles: never both gnt, no rvalid without a prior read, and no requester waits more than MAX_BURST+1 cycles while continuously requesting.
